// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs, status codes,
// the E pipeline register layout and the forwarding selector.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  localparam logic [2:0] SAOK = 3'd0;
  localparam logic [2:0] SHLT = 3'd1;
  localparam logic [2:0] SADR = 3'd2;
  localparam logic [2:0] SINS = 3'd3;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] val_c;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
  } e_reg_t;

  function automatic e_reg_t e_bubble_value();
    e_reg_t b;
    b       = '0;
    b.stat  = SAOK;
    b.icode = INOP;
    b.dst_e = RNONE;
    b.dst_m = RNONE;
    b.src_a = RNONE;
    b.src_b = RNONE;
    return b;
  endfunction

  // Youngest producer wins; RNONE never matches a source.
  function automatic logic [63:0] fwd_sel(
    input logic [3:0]  src,
    input logic [63:0] rf_val,
    input logic [3:0]  e_dst_e, input logic [63:0] e_val_e,
    input logic [3:0]  m_dst_m, input logic [63:0] m_val_m,
    input logic [3:0]  m_dst_e, input logic [63:0] m_val_e,
    input logic [3:0]  w_dst_m, input logic [63:0] w_val_m,
    input logic [3:0]  w_dst_e, input logic [63:0] w_val_e
  );
    if (src == RNONE)        return '0;
    else if (src == e_dst_e) return e_val_e;
    else if (src == m_dst_m) return m_val_m;
    else if (src == m_dst_e) return m_val_e;
    else if (src == w_dst_m) return w_val_m;
    else if (src == w_dst_e) return w_val_e;
    else                     return rf_val;
  endfunction

endpackage

// File: rtl/y86_decode_stage_if.sv
// Decode-stage bundle: D register in, forwarding sources, W write ports, E register out.
interface y86_decode_stage_if;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic        E_bubble;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  d_srcA, d_srcB;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;

  modport master (
    output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, E_bubble,
    output e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM, W_dstE, W_valE, W_dstM, W_valM,
    input  d_srcA, d_srcB,
    input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB
  );

  modport slave (
    input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, E_bubble,
    input  e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM, W_dstE, W_valE, W_dstM, W_valM,
    output d_srcA, d_srcB,
    output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB
  );
endinterface

// File: rtl/y86_regfile.sv
// 15 x 64 register file, two combinational reads, two writes; M port wins on same ID.
module y86_regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m,
  output logic [63:0] val_a,
  output logic [63:0] val_b
);

  logic [63:0] regs_q [15];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
    end else begin
      if (dst_e != RNONE) regs_q[dst_e] <= val_e;
      // Later assignment takes effect, so val_m wins when both target one ID.
      if (dst_m != RNONE) regs_q[dst_m] <= val_m;
    end
  end

  assign val_a = (src_a == RNONE) ? '0 : regs_q[src_a];
  assign val_b = (src_b == RNONE) ? '0 : regs_q[src_b];

endmodule

// File: rtl/y86_decode_stage.sv
// Y86-64 decode/write-back: source/destination selection, forwarding, E register.
module y86_decode_stage
  import y86_pkg::*;
(
  input logic              clk,
  input logic              reset,
  y86_decode_stage_if.slave bus
);

  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [63:0] rf_a, rf_b, fwd_a, fwd_b;
  e_reg_t      e_d, e_q;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (bus.D_icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src_a = bus.D_rA;
      IRET, IPOPQ:                    src_a = RSP;
      default:                        src_a = RNONE;
    endcase
    case (bus.D_icode)
      IRMMOVQ, IMRMOVQ, IOPQ:      src_b = bus.D_rB;
      ICALL, IRET, IPUSHQ, IPOPQ:  src_b = RSP;
      default:                     src_b = RNONE;
    endcase
    case (bus.D_icode)
      IRRMOVQ, IIRMOVQ, IOPQ:      dst_e = bus.D_rB;
      ICALL, IRET, IPUSHQ, IPOPQ:  dst_e = RSP;
      default:                     dst_e = RNONE;
    endcase
    case (bus.D_icode)
      IMRMOVQ, IPOPQ: dst_m = bus.D_rA;
      default:        dst_m = RNONE;
    endcase
  end

  y86_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .src_a (src_a),
    .src_b (src_b),
    .dst_e (bus.W_dstE),
    .val_e (bus.W_valE),
    .dst_m (bus.W_dstM),
    .val_m (bus.W_valM),
    .val_a (rf_a),
    .val_b (rf_b)
  );

  always_comb begin
    fwd_a = fwd_sel(src_a, rf_a, bus.e_dstE, bus.e_valE, bus.M_dstM, bus.m_valM,
                    bus.M_dstE, bus.M_valE, bus.W_dstM, bus.W_valM, bus.W_dstE, bus.W_valE);
    fwd_b = fwd_sel(src_b, rf_b, bus.e_dstE, bus.e_valE, bus.M_dstM, bus.m_valM,
                    bus.M_dstE, bus.M_valE, bus.W_dstM, bus.W_valM, bus.W_dstE, bus.W_valE);
  end

  always_comb begin
    e_d       = '0;
    e_d.stat  = bus.D_stat;
    e_d.icode = bus.D_icode;
    e_d.ifun  = bus.D_ifun;
    e_d.val_c = bus.D_valC;
    // Jumps and calls carry valP through valA instead of a register value.
    e_d.val_a = (bus.D_icode == IJXX || bus.D_icode == ICALL) ? bus.D_valP : fwd_a;
    e_d.val_b = fwd_b;
    e_d.dst_e = dst_e;
    e_d.dst_m = dst_m;
    e_d.src_a = src_a;
    e_d.src_b = src_b;
  end

  always_ff @(posedge clk) begin
    if (reset || bus.E_bubble) e_q <= e_bubble_value();
    else                       e_q <= e_d;
  end

  assign bus.d_srcA  = src_a;
  assign bus.d_srcB  = src_b;
  assign bus.E_stat  = e_q.stat;
  assign bus.E_icode = e_q.icode;
  assign bus.E_ifun  = e_q.ifun;
  assign bus.E_valC  = e_q.val_c;
  assign bus.E_valA  = e_q.val_a;
  assign bus.E_valB  = e_q.val_b;
  assign bus.E_dstE  = e_q.dst_e;
  assign bus.E_dstM  = e_q.dst_m;
  assign bus.E_srcA  = e_q.src_a;
  assign bus.E_srcB  = e_q.src_b;

endmodule

// File: tb/tb_y86_decode_stage.sv
// Directed-vector bench for the Y86-64 decode stage.
module tb_y86_decode_stage;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  y86_decode_stage_if bus();

  y86_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.D_stat = 3'd0; bus.D_icode = 4'h1; bus.D_ifun = 4'h0;
    bus.D_rA = 4'hF; bus.D_rB = 4'hF; bus.D_valC = '0; bus.D_valP = '0;
    bus.E_bubble = 1'b0;
    bus.e_dstE = 4'hF; bus.e_valE = '0;
    bus.M_dstE = 4'hF; bus.M_valE = '0; bus.M_dstM = 4'hF; bus.m_valM = '0;
    bus.W_dstE = 4'hF; bus.W_valE = '0; bus.W_dstM = 4'hF; bus.W_valM = '0;
  endtask

  task automatic decode(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb);
    bus.D_icode = icode; bus.D_ifun = 4'h0; bus.D_rA = ra; bus.D_rB = rb;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    decode(4'h6, 4'h1, 4'h2);
    bus.D_stat = 3'd3;
    tick();
    checks++;
    if (bus.E_icode !== 4'h1 || bus.E_stat !== 3'd0 || bus.E_dstE !== 4'hF ||
        bus.E_dstM !== 4'hF || bus.E_srcA !== 4'hF || bus.E_srcB !== 4'hF ||
        bus.E_valA !== 64'd0 || bus.E_valB !== 64'd0 || bus.E_valC !== 64'd0) begin
      failures++;
      $display("FAIL reset_bubble: icode=%h stat=%h dstE=%h dstM=%h srcA=%h srcB=%h want 1 0 f f f f",
               bus.E_icode, bus.E_stat, bus.E_dstE, bus.E_dstM, bus.E_srcA, bus.E_srcB);
    end
    drive_idle();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.E_icode !== 4'h1 || bus.E_dstE !== 4'hF || bus.E_dstM !== 4'hF) begin
      failures++;
      $display("FAIL idle_nop: icode=%h dstE=%h dstM=%h want 1 f f",
               bus.E_icode, bus.E_dstE, bus.E_dstM);
    end
    for (int i = 0; i < 15; i++) begin
      decode(4'h2, 4'(i), 4'h0);
      #1;
      checks++;
      if (bus.d_srcA !== 4'(i)) begin
        failures++;
        $display("FAIL d_srcA_%0d: got %h want %h", i, bus.d_srcA, 4'(i));
      end
      tick();
      checks++;
      if (bus.E_valA !== 64'd0) begin
        failures++;
        $display("FAIL rf_zero_r%0d: got %h want 0", i, bus.E_valA);
      end
    end
    drive_idle();
  endtask

  task automatic test_regfile_write();
    drive_idle();
    bus.W_dstE = 4'h3; bus.W_valE = 64'd5;
    tick();
    drive_idle();
    decode(4'h6, 4'h1, 4'h3);
    tick();
    checks++;
    if (bus.E_valB !== 64'd5 || bus.E_valA !== 64'd0 || bus.E_dstE !== 4'h3 ||
        bus.E_srcA !== 4'h1 || bus.E_srcB !== 4'h3 || bus.E_icode !== 4'h6) begin
      failures++;
      $display("FAIL rf_write_read: valB=%h valA=%h dstE=%h srcA=%h srcB=%h want 5 0 3 1 3",
               bus.E_valB, bus.E_valA, bus.E_dstE, bus.E_srcA, bus.E_srcB);
    end
    drive_idle();
  endtask

  task automatic test_forward_priority();
    drive_idle();
    decode(4'h6, 4'h1, 4'h3);
    bus.e_dstE = 4'h3; bus.e_valE = 64'd7;
    bus.M_dstE = 4'h3; bus.M_valE = 64'd9;
    bus.W_dstE = 4'h3; bus.W_valE = 64'd11;
    tick();
    checks++;
    if (bus.E_valB !== 64'd7) begin
      failures++;
      $display("FAIL fwd_e: got %0d want 7", bus.E_valB);
    end
    bus.e_dstE = 4'hF;
    tick();
    checks++;
    if (bus.E_valB !== 64'd9) begin
      failures++;
      $display("FAIL fwd_M_valE: got %0d want 9", bus.E_valB);
    end
    bus.M_dstE = 4'hF;
    tick();
    checks++;
    if (bus.E_valB !== 64'd11) begin
      failures++;
      $display("FAIL fwd_W_valE: got %0d want 11", bus.E_valB);
    end
    bus.W_dstE = 4'hF;
    tick();
    checks++;
    if (bus.E_valB !== 64'd11) begin
      failures++;
      $display("FAIL rf_after_fwd: got %0d want 11", bus.E_valB);
    end
    drive_idle();
  endtask

  task automatic test_mem_priority();
    drive_idle();
    decode(4'h2, 4'h2, 4'h5);
    bus.M_dstM = 4'h2; bus.m_valM = 64'hAA;
    bus.M_dstE = 4'h2; bus.M_valE = 64'hBB;
    tick();
    checks++;
    if (bus.E_valA !== 64'hAA || bus.E_dstE !== 4'h5 || bus.E_dstM !== 4'hF ||
        bus.E_valB !== 64'd0 || bus.E_srcB !== 4'hF) begin
      failures++;
      $display("FAIL fwd_mem_order: valA=%h dstE=%h dstM=%h valB=%h want aa 5 f 0",
               bus.E_valA, bus.E_dstE, bus.E_dstM, bus.E_valB);
    end
    drive_idle();
    decode(4'h2, 4'hF, 4'h5);
    bus.e_dstE = 4'hF; bus.e_valE = 64'h77;
    tick();
    checks++;
    if (bus.E_valA !== 64'd0) begin
      failures++;
      $display("FAIL rnone_no_fwd: got %h want 0", bus.E_valA);
    end
    drive_idle();
  endtask

  task automatic test_popq_writeback();
    drive_idle();
    bus.W_dstE = 4'h4; bus.W_valE = 64'h100;
    bus.W_dstM = 4'h4; bus.W_valM = 64'h55;
    tick();
    drive_idle();
    decode(4'h8, 4'hF, 4'hF);
    bus.D_valP = 64'h20; bus.D_valC = 64'h1234;
    #1;
    checks++;
    if (bus.d_srcB !== 4'h4 || bus.d_srcA !== 4'hF) begin
      failures++;
      $display("FAIL call_srcs: srcA=%h srcB=%h want f 4", bus.d_srcA, bus.d_srcB);
    end
    tick();
    checks++;
    if (bus.E_valA !== 64'h20 || bus.E_srcB !== 4'h4 || bus.E_dstE !== 4'h4 ||
        bus.E_valB !== 64'h55 || bus.E_valC !== 64'h1234) begin
      failures++;
      $display("FAIL call_decode: valA=%h srcB=%h dstE=%h valB=%h valC=%h want 20 4 4 55 1234",
               bus.E_valA, bus.E_srcB, bus.E_dstE, bus.E_valB, bus.E_valC);
    end
    drive_idle();
  endtask

  task automatic test_bubble_and_reset();
    drive_idle();
    decode(4'h5, 4'h6, 4'h7);
    bus.D_stat = 3'd2;
    bus.E_bubble = 1'b1;
    bus.W_dstE = 4'h6; bus.W_valE = 64'h99;
    tick();
    checks++;
    if (bus.E_icode !== 4'h1 || bus.E_dstM !== 4'hF || bus.E_stat !== 3'd0) begin
      failures++;
      $display("FAIL bubble: icode=%h dstM=%h stat=%h want 1 f 0",
               bus.E_icode, bus.E_dstM, bus.E_stat);
    end
    drive_idle();
    decode(4'h2, 4'h6, 4'h0);
    tick();
    checks++;
    if (bus.E_valA !== 64'h99) begin
      failures++;
      $display("FAIL write_during_bubble: got %h want 99", bus.E_valA);
    end
    decode(4'h5, 4'h6, 4'h7);
    bus.D_stat = 3'd2;
    tick();
    checks++;
    if (bus.E_icode !== 4'h5 || bus.E_dstM !== 4'h6 || bus.E_srcB !== 4'h7 ||
        bus.E_stat !== 3'd2 || bus.E_dstE !== 4'hF) begin
      failures++;
      $display("FAIL mrmovq: icode=%h dstM=%h srcB=%h stat=%h dstE=%h want 5 6 7 2 f",
               bus.E_icode, bus.E_dstM, bus.E_srcB, bus.E_stat, bus.E_dstE);
    end
    reset = 1'b1;
    bus.W_dstE = 4'h6; bus.W_valE = 64'h44;
    tick();
    checks++;
    if (bus.E_icode !== 4'h1 || bus.E_dstM !== 4'hF) begin
      failures++;
      $display("FAIL reset_mid: icode=%h dstM=%h want 1 f", bus.E_icode, bus.E_dstM);
    end
    reset = 1'b0;
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      logic [3:0] r;
      r = (k == 0) ? 4'h6 : (k == 1) ? 4'h3 : 4'h4;
      decode(4'h2, r, 4'h0);
      tick();
      checks++;
      if (bus.E_valA !== 64'd0) begin
        failures++;
        $display("FAIL rf_cleared_r%0d: got %h want 0", r, bus.E_valA);
      end
    end
    drive_idle();
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_regfile_write();
    test_forward_priority();
    test_mem_priority();
    test_popq_writeback();
    test_bubble_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
